// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multicycle control sequencer for the MIPS-subset datapath.
// Memory wait latency, mult/div done handshake with timeout, vectored exceptions.
//
// Ports:
//   clk, reset (async, active-low)
//   opcode, funct        - IR fields, stable from FETCH to the next FETCH
//   zero, overflow       - ALU status flags
//   md_done, div0        - mult/div unit handshake
//   pc_write .. epc_write - datapath mux selects and write enables
//   exc_cause            - cause of the most recent exception (held)
module mc_control_fsm #(
    parameter int          MEM_LAT  = 1,
    parameter int          MD_MAX   = 40,
    parameter logic [7:0]  EXC_BASE = 8'd253
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       overflow,
    input  logic       md_done,
    input  logic       div0,
    output logic       pc_write,
    output logic [1:0] pc_source,
    output logic [1:0] iord,
    output logic       mem_write,
    output logic       ir_write,
    output logic       ab_load,
    output logic       reg_write,
    output logic [1:0] reg_dst,
    output logic [1:0] mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_op,
    output logic       alu_out_load,
    output logic       md_start,
    output logic       md_sel,
    output logic       hilo_write,
    output logic       epc_write,
    output logic [1:0] exc_cause
);

    localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam int MW = $clog2(MD_MAX);

    // The cause-0 vector must not alias the reset fetch address.
    if (MEM_LAT < 1 || MD_MAX < 2 || EXC_BASE == 8'd0) begin : g_bad_param
        $error("mc_control_fsm: illegal parameter value");
    end

    typedef enum logic [4:0] {
        S_RESET, S_FETCH, S_DECODE, S_R_EX, S_R_WB, S_I_EX, S_I_WB,
        S_ADDR, S_MEM_RD, S_LW_WB, S_MEM_WR, S_BR, S_JMP, S_JR,
        S_MD_START, S_MD_WAIT, S_MD_WB, S_EXC_SAVE, S_EXC_MEM
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] mem_cnt;
    logic [MW-1:0] md_cnt;
    logic [1:0]    cause_q, cause_n;
    logic          mem_state, mem_last;
    logic          is_div, ovf_chk, taken;

    assign mem_state = (state == S_FETCH) || (state == S_MEM_RD) ||
                       (state == S_MEM_WR) || (state == S_EXC_MEM);
    assign mem_last  = (mem_cnt == CW'(MEM_LAT - 1));
    assign is_div    = (funct == 6'h1A);
    // Only ADD/SUB trap on overflow among the R-type ops.
    assign ovf_chk   = (funct == 6'h20) || (funct == 6'h22);
    assign taken     = (opcode == 6'h04) ? zero : !zero;
    assign exc_cause = cause_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_RESET;
            mem_cnt <= '0;
            md_cnt  <= '0;
            cause_q <= 2'd0;
        end else begin
            state   <= state_n;
            mem_cnt <= (mem_state && !mem_last) ? mem_cnt + 1'b1 : '0;
            md_cnt  <= (state == S_MD_WAIT) ? md_cnt + 1'b1 : '0;
            if (state_n == S_EXC_SAVE)
                cause_q <= cause_n;
        end
    end

    always_comb begin
        state_n = state;
        cause_n = cause_q;
        unique case (state)
            S_RESET:  state_n = S_FETCH;
            S_FETCH:  if (mem_last) state_n = S_DECODE;
            S_DECODE: begin
                state_n = S_EXC_SAVE;
                cause_n = 2'd0;
                case (opcode)
                    6'h00: case (funct)
                        6'h20, 6'h22, 6'h24, 6'h2A: state_n = S_R_EX;
                        6'h18, 6'h1A:               state_n = S_MD_START;
                        6'h08:                      state_n = S_JR;
                        default:                    state_n = S_EXC_SAVE;
                    endcase
                    6'h08:        state_n = S_I_EX;
                    6'h23, 6'h2B: state_n = S_ADDR;
                    6'h04, 6'h05: state_n = S_BR;
                    6'h02:        state_n = S_JMP;
                    default:      state_n = S_EXC_SAVE;
                endcase
            end
            S_R_EX: state_n = S_R_WB;
            S_R_WB: begin
                state_n = S_FETCH;
                if (ovf_chk && overflow) begin
                    state_n = S_EXC_SAVE;
                    cause_n = 2'd1;
                end
            end
            S_I_EX: state_n = S_I_WB;
            S_I_WB: begin
                state_n = S_FETCH;
                if (overflow) begin
                    state_n = S_EXC_SAVE;
                    cause_n = 2'd1;
                end
            end
            S_ADDR:   state_n = (opcode == 6'h2B) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD: if (mem_last) state_n = S_LW_WB;
            S_LW_WB:  state_n = S_FETCH;
            S_MEM_WR: if (mem_last) state_n = S_FETCH;
            S_BR, S_JMP, S_JR: state_n = S_FETCH;
            S_MD_START: state_n = S_MD_WAIT;
            S_MD_WAIT: begin
                // done is tested first so it wins a tie with the timeout
                if (md_done) begin
                    if (div0 && is_div) begin
                        state_n = S_EXC_SAVE;
                        cause_n = 2'd2;
                    end else begin
                        state_n = S_MD_WB;
                    end
                end else if (md_cnt == MW'(MD_MAX - 1)) begin
                    state_n = S_EXC_SAVE;
                    cause_n = 2'd3;
                end
            end
            S_MD_WB:    state_n = S_FETCH;
            S_EXC_SAVE: state_n = S_EXC_MEM;
            S_EXC_MEM:  if (mem_last) state_n = S_FETCH;
            default:    state_n = S_RESET;
        endcase
    end

    always_comb begin
        pc_write     = 1'b0;
        pc_source    = 2'd0;
        iord         = 2'd0;
        mem_write    = 1'b0;
        ir_write     = 1'b0;
        ab_load      = 1'b0;
        reg_write    = 1'b0;
        reg_dst      = 2'd0;
        mem_to_reg   = 2'd0;
        alu_src_a    = 1'b0;
        alu_src_b    = 2'd0;
        alu_op       = 3'b000;
        alu_out_load = 1'b0;
        md_start     = 1'b0;
        md_sel       = 1'b0;
        hilo_write   = 1'b0;
        epc_write    = 1'b0;
        unique case (state)
            S_FETCH: begin
                alu_src_b = 2'd1;
                alu_op    = 3'b001;
                ir_write  = mem_last;
                pc_write  = mem_last;
            end
            S_DECODE: begin
                ab_load      = 1'b1;
                alu_out_load = 1'b1;
                alu_src_b    = 2'd3;
                alu_op       = 3'b001;
            end
            S_R_EX: begin
                alu_src_a    = 1'b1;
                alu_out_load = 1'b1;
                case (funct)
                    6'h22:   alu_op = 3'b010;
                    6'h24:   alu_op = 3'b011;
                    6'h2A:   alu_op = 3'b111;
                    default: alu_op = 3'b001;
                endcase
            end
            S_R_WB: begin
                reg_write = !(ovf_chk && overflow);
                reg_dst   = 2'd1;
            end
            S_I_EX, S_ADDR: begin
                alu_src_a    = 1'b1;
                alu_src_b    = 2'd2;
                alu_op       = 3'b001;
                alu_out_load = 1'b1;
            end
            S_I_WB:   reg_write = !overflow;
            S_MEM_RD: iord = 2'd1;
            S_LW_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 2'd1;
            end
            S_MEM_WR: begin
                iord      = 2'd1;
                mem_write = mem_last;
            end
            S_BR: begin
                alu_src_a = 1'b1;
                alu_op    = 3'b010;
                pc_write  = taken;
                pc_source = 2'd1;
            end
            S_JMP: begin
                pc_write  = 1'b1;
                pc_source = 2'd2;
            end
            S_JR: begin
                pc_write  = 1'b1;
                alu_src_a = 1'b1;
            end
            S_MD_START: begin
                md_start = 1'b1;
                md_sel   = is_div;
            end
            S_MD_WAIT: md_sel = is_div;
            S_MD_WB: begin
                md_sel     = is_div;
                hilo_write = 1'b1;
            end
            S_EXC_SAVE: begin
                epc_write = 1'b1;
                alu_src_b = 2'd1;
                alu_op    = 3'b010;
            end
            S_EXC_MEM: begin
                iord      = 2'd2;
                pc_source = 2'd3;
                pc_write  = mem_last;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mc_control_fsm.sv
// tb_mc_control_fsm: directed bench for mc_control_fsm
// with MEM_LAT=3 and MD_MAX=40.
module tb_mc_control_fsm;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [5:0] opcode = 6'h00;
    logic [5:0] funct = 6'h20;
    logic       zero = 1'b0;
    logic       overflow = 1'b0;
    logic       md_done = 1'b0;
    logic       div0 = 1'b0;
    logic       pc_write, mem_write, ir_write, ab_load, reg_write;
    logic       alu_src_a, alu_out_load, md_start, md_sel;
    logic       hilo_write, epc_write;
    logic [1:0] pc_source, iord, reg_dst, mem_to_reg, alu_src_b;
    logic [1:0] exc_cause;
    logic [2:0] alu_op;

    int errs = 0;
    int chks = 0;

    always #5 clk = ~clk;

    mc_control_fsm #(.MEM_LAT(3), .MD_MAX(40), .EXC_BASE(8'd253)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
        .zero(zero), .overflow(overflow), .md_done(md_done), .div0(div0),
        .pc_write(pc_write), .pc_source(pc_source), .iord(iord),
        .mem_write(mem_write), .ir_write(ir_write), .ab_load(ab_load),
        .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .alu_out_load(alu_out_load), .md_start(md_start), .md_sel(md_sel),
        .hilo_write(hilo_write), .epc_write(epc_write),
        .exc_cause(exc_cause)
    );

    logic [31:0] all_out;
    assign all_out = {6'd0, pc_write, pc_source, iord, mem_write, ir_write,
                      ab_load, reg_write, reg_dst, mem_to_reg, alu_src_a,
                      alu_src_b, alu_op, alu_out_load, md_start, md_sel,
                      hilo_write, epc_write, exc_cause};

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        chks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Entered on FETCH cycle 0; leaves the FSM in DECODE.
    task automatic run_fetch(input logic [5:0] op, input logic [5:0] fn);
        opcode = op;
        funct  = fn;
        chk("fetch_c0_ir", 32'(ir_write), 32'd0);
        tick();
        tick();
        chk("fetch_last_ir", 32'(ir_write), 32'd1);
        chk("fetch_last_pc", 32'(pc_write), 32'd1);
        tick();
        chk("decode_ab", 32'(ab_load), 32'd1);
    endtask

    // Entered in EXC_SAVE; leaves the FSM on FETCH cycle 0.
    task automatic exc_tail(input logic [1:0] cause);
        chk("exc_epc", 32'(epc_write), 32'd1);
        chk("exc_cause", 32'(exc_cause), 32'(cause));
        tick();
        chk("exc_mem_iord", 32'(iord), 32'd2);
        chk("exc_mem_c0_pc", 32'(pc_write), 32'd0);
        tick();
        tick();
        chk("exc_mem_last", {30'd0, pc_write, (pc_source == 2'd3)}, 32'd3);
        tick();
        chk("exc_back_fetch", {30'd0, iord}, 32'd0);
        chk("exc_cause_held", 32'(exc_cause), 32'(cause));
    endtask

    // Entered in DECODE of a MULT/DIV; leaves the FSM on MD_WAIT cycle n.
    task automatic md_to_cycle(input int n, inout int hw);
        tick();
        chk("md_start", {30'd0, md_start, md_sel}, {30'd0, 1'b1, (funct == 6'h1A)});
        for (int i = 1; i <= n; i++) begin
            tick();
            if (hilo_write) hw++;
            if (i == 1) chk("md_start_pulse", 32'(md_start), 32'd0);
        end
        chk("md_wait_no_epc", 32'(epc_write), 32'd0);
    endtask

    initial begin
        int hw;
        #2;
        chk("reset_outs", all_out, 32'd0);
        reset = 1'b1;
        tick();
        chk("fetch_c0_iord", 32'(iord), 32'd0);
        chk("fetch_c0_pcw", 32'(pc_write), 32'd0);

        // ADD with overflow
        run_fetch(6'h00, 6'h20);
        tick();
        chk("rex_alu", {28'd0, alu_src_a, alu_op}, {28'd0, 1'b1, 3'b001});
        overflow = 1'b1;
        tick();
        chk("rwb_ovf_noreg", 32'(reg_write), 32'd0);
        tick();
        overflow = 1'b0;
        chk("exc_save_aluop", 32'(alu_op), 32'd2);
        exc_tail(2'd1);

        // illegal opcode
        run_fetch(6'h3F, 6'h00);
        tick();
        exc_tail(2'd0);

        // BEQ taken, BNE not taken
        zero = 1'b1;
        run_fetch(6'h04, 6'h00);
        tick();
        chk("beq_taken", {29'd0, pc_write, pc_source}, {29'd0, 1'b1, 2'd1});
        tick();
        run_fetch(6'h05, 6'h00);
        tick();
        chk("bne_not_taken", 32'(pc_write), 32'd0);
        zero = 1'b0;
        tick();

        // J
        run_fetch(6'h02, 6'h00);
        tick();
        chk("jmp", {29'd0, pc_write, pc_source}, {29'd0, 1'b1, 2'd2});
        tick();

        // DIV by zero at wait cycle 5
        hw = 0;
        run_fetch(6'h00, 6'h1A);
        md_to_cycle(5, hw);
        md_done = 1'b1;
        div0 = 1'b1;
        tick();
        md_done = 1'b0;
        div0 = 1'b0;
        if (hilo_write) hw++;
        chk("div0_no_hilo", 32'(hw), 32'd0);
        exc_tail(2'd2);

        // MULT done at wait cycle 5
        hw = 0;
        run_fetch(6'h00, 6'h18);
        md_to_cycle(5, hw);
        md_done = 1'b1;
        tick();
        md_done = 1'b0;
        chk("mult_hilo", {30'd0, hilo_write, epc_write}, 32'd2);
        tick();
        chk("mult_hilo_once", {30'd0, hilo_write, ir_write}, 32'd0);
        chk("mult_fetch_iord", 32'(iord), 32'd0);

        // MULT timeout after exactly 40 wait cycles
        hw = 0;
        run_fetch(6'h00, 6'h18);
        md_to_cycle(40, hw);
        tick();
        exc_tail(2'd3);

        // MULT done exactly on wait cycle 40
        run_fetch(6'h00, 6'h18);
        md_to_cycle(40, hw);
        md_done = 1'b1;
        tick();
        md_done = 1'b0;
        chk("md_tie_done", {30'd0, hilo_write, epc_write}, 32'd2);
        chk("md_no_hilo_early", 32'(hw), 32'd0);
        tick();

        // SW aborted by reset mid-MEM_WR
        run_fetch(6'h2B, 6'h00);
        tick();
        chk("addr_alu", {29'd0, alu_src_a, alu_src_b}, {29'd0, 1'b1, 2'd2});
        tick();
        chk("memwr_c0", {29'd0, iord, mem_write}, {29'd0, 2'd1, 1'b0});
        tick();
        chk("memwr_c1", 32'(mem_write), 32'd0);
        #2;
        reset = 1'b0;
        #1;
        chk("async_reset_outs", all_out, 32'd0);
        hw = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (mem_write) hw++;
        end
        chk("abort_no_memwr", 32'(hw), 32'd0);
        reset = 1'b1;
        tick();
        chk("refetch_after_abort", {29'd0, iord, ir_write}, 32'd0);
        tick();
        tick();
        chk("refetch_last_ir", 32'(ir_write), 32'd1);

        $display("Result: errors=%0d of %0d checks", errs, chks);
        $finish;
    end

endmodule
